// File: rtl/ft601_rx_reader_if.sv
// FT601 receive-side pin bundle plus the downstream valid/ready stream.
// The reader itself is the master; the FT601 pins and the packet router together form the slave.
interface ft601_rx_reader_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]   usb_data;
    logic [WIDTH/8-1:0] usb_be;
    logic               usb_rx_empty;
    logic               usb_rden_l;
    logic               usb_outen_l;
    logic               m_valid;
    logic [WIDTH-1:0]   m_data;
    logic [WIDTH/8-1:0] m_be;
    logic               m_ready;

    modport master (
        input  usb_data, usb_be, usb_rx_empty, m_ready,
        output usb_rden_l, usb_outen_l, m_valid, m_data, m_be
    );

    modport slave (
        output usb_data, usb_be, usb_rx_empty, m_ready,
        input  usb_rden_l, usb_outen_l, m_valid, m_data, m_be
    );
endinterface

// File: rtl/ft601_rx_reader.sv
// FT601 245-sync-FIFO burst read master.
// Captured words go into a small first-word-fall-through buffer that feeds a valid/ready stream.
module ft601_rx_reader #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int MAX_BURST = 64
) (
    input  logic                     clk,
    input  logic                     rst_l,
    ft601_rx_reader_if.master        bus,
    output logic                     rd_active,
    output logic [31:0]              word_count
);
    localparam int BE_W    = WIDTH / 8;
    localparam int ENTRY_W = WIDTH + BE_W;
    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = $clog2(DEPTH + 1);
    localparam int BW      = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE,
        TURNAROUND,
        READ,
        RELEASE
    } state_t;

    state_t state, next_state;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count, count_next;
    logic [BW-1:0]      burst_cnt;
    logic               push, pop, burst_done, full_next;

    // The bus is only sampled in READ, where rden_l is already low.
    assign push       = (state == READ) && !bus.usb_rx_empty;
    assign pop        = bus.m_valid && bus.m_ready;
    assign count_next = count + CW'(push) - CW'(pop);
    assign burst_done = (burst_cnt + BW'(push)) == BW'(MAX_BURST);
    assign full_next  = (count_next == CW'(DEPTH));

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (!bus.usb_rx_empty && count <= CW'(DEPTH - 2)) next_state = TURNAROUND;
            TURNAROUND: next_state = READ;
            READ:       if (bus.usb_rx_empty || burst_done || full_next) next_state = RELEASE;
            RELEASE:    next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state           <= IDLE;
            bus.usb_rden_l  <= 1'b1;
            bus.usb_outen_l <= 1'b1;
            burst_cnt       <= '0;
            word_count      <= '0;
            count           <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
        end else begin
            state           <= next_state;
            // Pin strobes are registered decodes of the state being entered.
            bus.usb_rden_l  <= (next_state != READ);
            bus.usb_outen_l <= !((next_state == TURNAROUND) || (next_state == READ));
            if (state == TURNAROUND)
                burst_cnt <= '0;
            else if (push)
                burst_cnt <= burst_cnt + BW'(1);
            if (push) begin
                word_count <= word_count + 32'd1;
                wr_ptr     <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
        end
    end

    // NOTE: storage is deliberately not reset; count gates m_valid, so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {bus.usb_be, bus.usb_data};
    end

    assign {bus.m_be, bus.m_data} = mem[rd_ptr];
    assign bus.m_valid            = (count != '0);
    assign rd_active              = (state == TURNAROUND) || (state == READ);

    // READ is left before the buffer can fill, so a capture into a full buffer is a design bug.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_l)
        !(push && count == CW'(DEPTH)));
endmodule

// File: tb/tb_ft601_rx_reader.sv
// Self-checking bench: two readers (MAX_BURST 64 and 4) fed by modelled FT601 sources.
// The model holds the ordered source words and the counts of words read out and consumed.
module tb_ft601_rx_reader;
    localparam int DEPTH = 8;
    localparam int MEM_N = 4096;
    localparam int BUR_N = 1024;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    always #5 clk = ~clk;

    logic        rx_empty [2];
    logic [31:0] data_in  [2];
    logic [3:0]  be_in    [2];
    logic        m_rdy    [2];
    logic        rden     [2];
    logic        outen    [2];
    logic        mv       [2];
    logic        rd_act   [2];
    logic [31:0] mdata    [2];
    logic [31:0] wcnt     [2];
    logic [3:0]  mbe      [2];
    logic        rd_active_a, rd_active_b;
    logic [31:0] word_count_a, word_count_b;

    ft601_rx_reader_if #(.WIDTH(32)) bus_a ();
    ft601_rx_reader_if #(.WIDTH(32)) bus_b ();

    ft601_rx_reader #(.WIDTH(32), .DEPTH(DEPTH), .MAX_BURST(64)) dut_a (
        .clk(clk), .rst_l(rst_l), .bus(bus_a), .rd_active(rd_active_a), .word_count(word_count_a));
    ft601_rx_reader #(.WIDTH(32), .DEPTH(DEPTH), .MAX_BURST(4)) dut_b (
        .clk(clk), .rst_l(rst_l), .bus(bus_b), .rd_active(rd_active_b), .word_count(word_count_b));

    assign bus_a.usb_rx_empty = rx_empty[0];
    assign bus_a.usb_data     = data_in[0];
    assign bus_a.usb_be       = be_in[0];
    assign bus_a.m_ready      = m_rdy[0];
    assign bus_b.usb_rx_empty = rx_empty[1];
    assign bus_b.usb_data     = data_in[1];
    assign bus_b.usb_be       = be_in[1];
    assign bus_b.m_ready      = m_rdy[1];
    assign rden[0]  = bus_a.usb_rden_l;   assign rden[1]  = bus_b.usb_rden_l;
    assign outen[0] = bus_a.usb_outen_l;  assign outen[1] = bus_b.usb_outen_l;
    assign mv[0]    = bus_a.m_valid;      assign mv[1]    = bus_b.m_valid;
    assign mdata[0] = bus_a.m_data;       assign mdata[1] = bus_b.m_data;
    assign mbe[0]   = bus_a.m_be;         assign mbe[1]   = bus_b.m_be;
    assign rd_act[0] = rd_active_a;       assign rd_act[1] = rd_active_b;
    assign wcnt[0]   = word_count_a;      assign wcnt[1]   = word_count_b;

    // Model state: words are delivered and consumed strictly in source order.
    logic [35:0] src_mem [2][MEM_N];
    int          src_wr [2];
    int          src_rd [2];
    int          pop_cnt [2];
    logic [31:0] wc_m [2];
    int          burst_cur [2];
    int          low_cur [2];
    int          nb [2];
    int          burst_len [2][BUR_N];
    int          low_len [2][BUR_N];
    int          gap_at [2];
    int          gap_seen [2];
    bit          rnd_mode;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input int i, input int n, input bit full_be);
        for (int k = 0; k < n; k++)
            src_mem[i][src_wr[i] + k] = {full_be ? 4'hF : 4'($urandom_range(0, 15)), 32'($urandom())};
        src_wr[i] = src_wr[i] + n;
    endtask

    task automatic drain(input int i);
        bit done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            done = (src_rd[i] == src_wr[i]) && (pop_cnt[i] == src_rd[i]) && rden[i] && outen[i];
        end
        check($sformatf("drain%0d_done", i), 64'(done), 64'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // FT601 source: a word is transferred at any edge where rden_l is low and data is present.
    initial begin
        for (int i = 0; i < 2; i++) begin
            src_wr[i] = 0; src_rd[i] = 0; pop_cnt[i] = 0; wc_m[i] = '0;
            burst_cur[i] = 0; low_cur[i] = 0; nb[i] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_l);
            if (!rst_l) begin
                for (int i = 0; i < 2; i++) begin
                    pop_cnt[i] = src_rd[i];
                    wc_m[i] = '0;
                    burst_cur[i] = 0;
                    low_cur[i] = 0;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (mv[i] && m_rdy[i]) pop_cnt[i]++;
                    if (!rden[i]) begin
                        low_cur[i]++;
                        if (!rx_empty[i]) begin
                            src_rd[i]++;
                            wc_m[i]++;
                            burst_cur[i]++;
                        end
                    end else if (low_cur[i] > 0) begin
                        if (nb[i] < BUR_N) begin
                            burst_len[i][nb[i]] = burst_cur[i];
                            low_len[i][nb[i]]   = low_cur[i];
                        end
                        nb[i]++;
                        burst_cur[i] = 0;
                        low_cur[i] = 0;
                    end
                end
            end
        end
    end

    // Source pin driver, updated on the falling edge.
    initial begin
        for (int i = 0; i < 2; i++) begin
            rx_empty[i] = 1'b1; data_in[i] = '0; be_in[i] = '0; gap_seen[i] = -1;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                bit avail;
                bit gap;
                avail = src_rd[i] < src_wr[i];
                gap   = (gap_at[i] >= 0) && (src_rd[i] == gap_at[i]) && (gap_seen[i] != gap_at[i]);
                if (gap) gap_seen[i] = gap_at[i];
                rx_empty[i] = !avail || gap || (rnd_mode && $urandom_range(0, 5) == 0);
                data_in[i]  = avail ? src_mem[i][src_rd[i]][31:0]  : 'x;
                be_in[i]    = avail ? src_mem[i][src_rd[i]][35:32] : 'x;
            end
        end
    end

    // Per-cycle comparison of both readers against the model.
    initial begin
        forever begin
            int occ;
            @(negedge clk);
            if (rst_l) begin
                for (int i = 0; i < 2; i++) begin
                    occ = src_rd[i] - pop_cnt[i];
                    check($sformatf("dut%0d.m_valid", i), 64'(mv[i]), 64'(occ != 0));
                    if (occ != 0)
                        check($sformatf("dut%0d.head", i), 64'({mbe[i], mdata[i]}), 64'(src_mem[i][pop_cnt[i]]));
                    check($sformatf("dut%0d.word_count", i), 64'(wcnt[i]), 64'(wc_m[i]));
                    check($sformatf("dut%0d.rd_active", i), 64'(rd_act[i]), 64'(!outen[i]));
                    check($sformatf("dut%0d.rden_without_outen", i), 64'(!rden[i] && outen[i]), 64'd0);
                    check($sformatf("dut%0d.occupancy_bound", i), 64'(occ <= DEPTH), 64'd1);
                end
            end
        end
    end

    initial begin
        int nb0;
        bit hit;
        rnd_mode = 1'b0;
        gap_at[0] = -1; gap_at[1] = -1;
        m_rdy[0] = 1'b0; m_rdy[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_l = 1'b1;

        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset%0d.rden_l", i), 64'(rden[i]), 64'd1);
            check($sformatf("reset%0d.outen_l", i), 64'(outen[i]), 64'd1);
            check($sformatf("reset%0d.m_valid", i), 64'(mv[i]), 64'd0);
            check($sformatf("reset%0d.word_count", i), 64'(wcnt[i]), 64'd0);
            check($sformatf("reset%0d.rd_active", i), 64'(rd_act[i]), 64'd0);
        end

        // Five words, consumer always ready.
        m_rdy[0] = 1'b1;
        @(posedge clk); #1;
        nb0 = nb[0];
        load(0, 5, 1'b1);
        @(posedge clk); #1;
        check("t1_outen_fall", 64'(outen[0]), 64'd0);
        check("t1_rden_in_turnaround", 64'(rden[0]), 64'd1);
        @(posedge clk); #1;
        check("t1_rden_fall", 64'(rden[0]), 64'd0);
        drain(0);
        check("t1_burst_count", 64'(nb[0] - nb0), 64'd1);
        check("t1_burst_len", 64'(burst_len[0][nb0]), 64'd5);
        check("t1_rden_low_cycles", 64'(low_len[0][nb0]), 64'd6);
        check("t1_word_count", 64'(wcnt[0]), 64'd5);

        // Consumer stalled: one burst fills the buffer, then the reader waits.
        m_rdy[0] = 1'b0;
        @(posedge clk); #1;
        nb0 = nb[0];
        load(0, 20, 1'b1);
        for (int k = 0; k < 200 && nb[0] == nb0; k++) @(negedge clk);
        check("t2_first_burst_len", 64'(burst_len[0][nb0]), 64'd8);
        repeat (10) @(negedge clk);
        check("t2_idle_rden", 64'(rden[0]), 64'd1);
        check("t2_idle_outen", 64'(outen[0]), 64'd1);
        check("t2_no_new_burst", 64'(nb[0] - nb0), 64'd1);
        check("t2_buffer_full", 64'(src_rd[0] - pop_cnt[0]), 64'd8);
        m_rdy[0] = 1'b1;
        drain(0);
        check("t2_word_count", 64'(wcnt[0]), 64'd25);

        // MAX_BURST = 4 reader, ten words.
        m_rdy[1] = 1'b1;
        @(posedge clk); #1;
        nb0 = nb[1];
        load(1, 10, 1'b1);
        drain(1);
        check("t3_burst_count", 64'(nb[1] - nb0), 64'd3);
        check("t3_burst0", 64'(burst_len[1][nb0]), 64'd4);
        check("t3_burst1", 64'(burst_len[1][nb0 + 1]), 64'd4);
        check("t3_burst2", 64'(burst_len[1][nb0 + 2]), 64'd2);
        check("t3_low2", 64'(low_len[1][nb0 + 2]), 64'd3);
        check("t3_word_count", 64'(wcnt[1]), 64'd10);

        // One-cycle empty gap after three words.
        @(posedge clk); #1;
        nb0 = nb[0];
        gap_at[0] = src_wr[0] + 3;
        load(0, 6, 1'b1);
        drain(0);
        check("t4_burst_count", 64'(nb[0] - nb0), 64'd2);
        check("t4_burst0", 64'(burst_len[0][nb0]), 64'd3);
        check("t4_burst1", 64'(burst_len[0][nb0 + 1]), 64'd3);
        check("t4_word_count", 64'(wcnt[0]), 64'd31);

        // Push and pop together with the buffer at DEPTH-1.
        m_rdy[0] = 1'b0;
        @(posedge clk); #1;
        nb0 = nb[0];
        load(0, 30, 1'b1);
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clk);
            hit = (src_rd[0] - pop_cnt[0]) == DEPTH - 1;
        end
        m_rdy[0] = 1'b1;
        check("t5_reached_depth_minus_1", 64'(hit), 64'd1);
        drain(0);
        check("t5_burst_count", 64'(nb[0] - nb0), 64'd1);
        check("t5_burst_len", 64'(burst_len[0][nb0]), 64'd30);
        check("t5_word_count", 64'(wcnt[0]), 64'd61);

        // Reset in the middle of a burst with three words buffered.
        m_rdy[0] = 1'b0;
        @(posedge clk); #1;
        load(0, 10, 1'b1);
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clk);
            hit = (src_rd[0] - pop_cnt[0]) == 3;
        end
        check("t6_in_read", 64'(rden[0]), 64'd0);
        #1 rst_l = 1'b0;
        #1;
        check("t6_rst_rden", 64'(rden[0]), 64'd1);
        check("t6_rst_outen", 64'(outen[0]), 64'd1);
        check("t6_rst_m_valid", 64'(mv[0]), 64'd0);
        check("t6_rst_word_count", 64'(wcnt[0]), 64'd0);
        @(posedge clk); #1;
        rst_l = 1'b1;
        m_rdy[0] = 1'b1;
        drain(0);
        check("t6_word_count_after", 64'(wcnt[0]), 64'd7);

        // Random traffic on both readers.
        rnd_mode = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                m_rdy[i] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 9) == 0 && src_wr[i] < MEM_N - 100)
                    load(i, $urandom_range(1, 12), 1'b0);
            end
        end
        rnd_mode = 1'b0;
        m_rdy[0] = 1'b1;
        m_rdy[1] = 1'b1;
        drain(0);
        drain(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
